// File: rtl/mem_port_arbiter.sv
// Single shared memory port arbiter for instruction fetch and data access.
// Data has priority, fetch is protected by a starvation limit, and every access runs issue/wait/response.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    input  logic              flush,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned SKIP_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int unsigned LAT_W  = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
    localparam logic [SKIP_W-1:0] SKIP_LIMIT = SKIP_W'(STARVE_MAX);
    localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_if;
    logic              fetch_active;

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        skip_cnt_d   = skip_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        drop_d       = drop_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        // Fetch wins a contested grant only once data has been granted STARVE_MAX times in a row.
        grant_if     = if_req && (!dm_req || (skip_cnt_q >= SKIP_LIMIT));
        fetch_active = (state_q != S_IDLE) && (owner_q == OWN_IF);

        unique case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (if_req || dm_req) begin
                    state_d = S_ISSUE;
                    if (grant_if) begin
                        owner_d     = OWN_IF;
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        skip_cnt_d  = '0;
                    end else begin
                        owner_d     = OWN_DM;
                        mem_addr_d  = dm_addr;
                        mem_we_d    = dm_we;
                        mem_wdata_d = dm_wdata;
                        if (if_req && (skip_cnt_q < SKIP_LIMIT)) begin
                            skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_d   = S_WAIT;
                lat_cnt_d = '0;
            end
            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d   = S_RESP;
                    lat_cnt_d = '0;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata[31:0];
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush in the response cycle masks if_valid directly, so only earlier cycles need the flag.
        if (fetch_active && flush && (state_q != S_RESP)) begin
            drop_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            skip_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            drop_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            skip_cnt_q  <= skip_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            drop_q      <= drop_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en && mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign if_valid  = (state_q == S_RESP) && (owner_q == OWN_IF) && !drop_q && !flush;
    assign dm_valid  = (state_q == S_RESP) && (owner_q == OWN_DM);

    // A dropped fetch keeps the fetch stage stalled until a fetch actually returns.
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 2;

    localparam logic [63:0] JUNK  = 64'hA5A5_5A5A_C3C3_3C3C;
    localparam logic [63:0] D1    = 64'h1122_3344_5566_7788;
    localparam logic [63:0] I1    = 64'hFFFF_0000_0013_0513;
    localparam logic [63:0] I2    = 64'h0000_0000_0040_0113;
    localparam logic [63:0] I3    = 64'h0000_0000_00A0_0293;
    localparam logic [63:0] D3    = 64'h0BAD_F00D_1234_5678;
    localparam logic [63:0] D4    = 64'h4444_3333_2222_1111;
    localparam logic [63:0] D_OLD = 64'h7777_6666_5555_4444;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_valid;
    logic        flush;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .ADDR_W    (64),
        .DATA_W    (64),
        .MEM_LAT   (LAT),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .flush    (flush),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic test_reset();
        logic [5:0] got_f;
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b0; dm_we = 1'b0; flush = 1'b0;
        if_addr = 64'h0; dm_addr = 64'h0; dm_wdata = 64'h0; mem_rdata = JUNK;
        #12;
        got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
        n_cmp++;
        if (got_f !== 6'b000010) begin
            n_bad++; $display("FAIL reset_flags: got %b want %b", got_f, 6'b000010);
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, dm_rdata, if_rdata} !== '0) begin
            n_bad++; $display("FAIL reset_data: got %h %h %h %h want all zero", mem_addr, mem_wdata, dm_rdata, if_rdata);
        end
        dm_req = 1'b1;
        #1;
        n_cmp++;
        if (stall_mem !== 1'b1) begin
            n_bad++; $display("FAIL reset_stall_mem: got %b want 1", stall_mem);
        end
        if_req = 1'b0; dm_req = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        logic [5:0] got_f, exp_f;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if_req = (c <= 4); if_addr = 64'h10;
            mem_rdata = (c == 3) ? 64'h0000_0000_0050_0093 : JUNK;
            settle();
            got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
            exp_f = {c == 1, 1'b0, c == 4, 1'b0, c <= 3, 1'b0};
            n_cmp++;
            if (got_f !== exp_f) begin
                n_bad++; $display("FAIL fetch_flags c%0d: got %b want %b", c, got_f, exp_f);
            end
            if (c == 1) begin
                n_cmp++;
                if (mem_addr !== 64'h10) begin
                    n_bad++; $display("FAIL fetch_addr: got %h want 10", mem_addr);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (if_rdata !== 32'h0050_0093) begin
                    n_bad++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] got_f, exp_f;
        logic [63:0] want_i;
        want_i = I1;
        for (int c = 0; c < 11; c++) begin
            next_cycle();
            if_req = (c <= 9); if_addr = 64'h40;
            dm_req = (c <= 4); dm_we = 1'b0; dm_addr = 64'h20;
            mem_rdata = (c == 3) ? D1 : (c == 8) ? I1 : JUNK;
            settle();
            got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
            exp_f = {c == 1 || c == 6, 1'b0, c == 9, c == 4, c <= 8, c <= 3};
            n_cmp++;
            if (got_f !== exp_f) begin
                n_bad++; $display("FAIL simul_flags c%0d: got %b want %b", c, got_f, exp_f);
            end
            if (c == 1 || c == 6) begin
                n_cmp++;
                if (mem_addr !== ((c == 1) ? 64'h20 : 64'h40)) begin
                    n_bad++; $display("FAIL simul_addr c%0d: got %h", c, mem_addr);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (dm_rdata !== D1) begin
                    n_bad++; $display("FAIL simul_dm_rdata: got %h want %h", dm_rdata, D1);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (if_rdata !== want_i[31:0]) begin
                    n_bad++; $display("FAIL simul_if_rdata: got %h want %h", if_rdata, want_i[31:0]);
                end
            end
        end
    endtask

    task automatic test_store();
        logic [5:0] got_f, exp_f;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if_req = 1'b0;
            dm_req = (c <= 4); dm_we = 1'b1; dm_addr = 64'h8; dm_wdata = 64'hDEAD_BEEF;
            mem_rdata = JUNK;
            settle();
            got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
            exp_f = {c == 1, c == 1, 1'b0, c == 4, 1'b0, c <= 3};
            n_cmp++;
            if (got_f !== exp_f) begin
                n_bad++; $display("FAIL store_flags c%0d: got %b want %b", c, got_f, exp_f);
            end
            if (c == 1 || c == 2) begin
                n_cmp++;
                if (mem_addr !== 64'h8 || mem_wdata !== 64'hDEAD_BEEF) begin
                    n_bad++; $display("FAIL store_addr_data c%0d: got %h/%h want 8/deadbeef", c, mem_addr, mem_wdata);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (dm_rdata !== D1) begin
                    n_bad++; $display("FAIL store_rdata_kept: got %h want %h", dm_rdata, D1);
                end
            end
        end
        dm_we = 1'b0;
    endtask

    task automatic test_starvation();
        logic [63:0] seq [6];
        logic [63:0] want;
        int  grants = 0;
        int  budget = 0;
        int  sk = 0;
        bit  done = 0;
        bit  pick_if;
        for (int i = 0; i < 6; i++) seq[i] = 64'h0;
        while (!done && budget < 60) begin
            next_cycle();
            budget++;
            if_req = 1'b1; if_addr = 64'h100;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
            mem_rdata = {$urandom, $urandom};
            settle();
            if (mem_en === 1'b1) begin
                if (grants < 6) seq[grants] = mem_addr;
                grants++;
            end
            if (grants == 6 && if_valid === 1'b1) done = 1;
        end
        next_cycle();
        if_req = 1'b0; dm_req = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL starve_budget: saw %0d grants, want 6 ending in a fetch", grants);
            repeat (LAT + 4) next_cycle();
        end
        for (int i = 0; i < 6; i++) begin
            pick_if = (sk >= SMAX);
            if (pick_if) sk = 0;
            else if (sk < SMAX) sk++;
            want = pick_if ? 64'h100 : 64'h200;
            n_cmp++;
            if (seq[i] !== want) begin
                n_bad++; $display("FAIL starve_order grant%0d: got %h want %h", i, seq[i], want);
            end
        end
    endtask

    task automatic test_flush();
        logic [5:0] got_f, exp_f;
        logic [63:0] want_i;
        for (int fc = 1; fc <= 4; fc++) begin
            want_i = I2 + 64'(fc);
            for (int c = 0; c < 11; c++) begin
                next_cycle();
                if_req = (c <= 9); if_addr = 64'h300 + 64'(fc * 4);
                dm_req = 1'b0;
                flush = (c == fc);
                mem_rdata = (c == 3) ? 64'h0000_0000_DEAD_0001 : (c == 8) ? want_i : JUNK;
                settle();
                got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
                exp_f = {c == 1 || c == 6, 1'b0, c == 9, 1'b0, c <= 8, 1'b0};
                n_cmp++;
                if (got_f !== exp_f) begin
                    n_bad++; $display("FAIL flush_at%0d_flags c%0d: got %b want %b", fc, c, got_f, exp_f);
                end
                if (c == 6) begin
                    n_cmp++;
                    if (mem_addr !== 64'h300 + 64'(fc * 4)) begin
                        n_bad++; $display("FAIL flush_at%0d_refetch_addr: got %h", fc, mem_addr);
                    end
                end
                if (c == 9) begin
                    n_cmp++;
                    if (if_rdata !== want_i[31:0]) begin
                        n_bad++; $display("FAIL flush_at%0d_rdata: got %h want %h", fc, if_rdata, want_i[31:0]);
                    end
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if_req = 1'b0;
            dm_req = (c <= 4); dm_we = 1'b0; dm_addr = 64'h48;
            flush = (c <= 4);
            mem_rdata = (c == 3) ? D4 : JUNK;
            settle();
            got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
            exp_f = {c == 1, 1'b0, 1'b0, c == 4, 1'b0, c <= 3};
            n_cmp++;
            if (got_f !== exp_f) begin
                n_bad++; $display("FAIL flush_dm_flags c%0d: got %b want %b", c, got_f, exp_f);
            end
            if (c == 4) begin
                n_cmp++;
                if (dm_rdata !== D4) begin
                    n_bad++; $display("FAIL flush_dm_rdata: got %h want %h", dm_rdata, D4);
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if_req = (c <= 4); if_addr = 64'h3F0;
            dm_req = 1'b0;
            flush = (c == 0);
            mem_rdata = (c == 3) ? I3 : JUNK;
            settle();
            got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
            exp_f = {c == 1, 1'b0, c == 4, 1'b0, c <= 3, 1'b0};
            n_cmp++;
            if (got_f !== exp_f) begin
                n_bad++; $display("FAIL flush_idle_flags c%0d: got %b want %b", c, got_f, exp_f);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [5:0] got_f, exp_f;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if_req = 1'b0;
            dm_req = (c <= 8); dm_we = 1'b0; dm_addr = 64'h28;
            mem_rdata = (c == 3) ? D_OLD : (c == 7) ? D3 : JUNK;
            if (c == 4) rst = 1'b1;
            if (c == 2) begin
                #2 rst = 1'b0;
                #1;
                got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
                n_cmp++;
                if (got_f !== 6'b000001) begin
                    n_bad++; $display("FAIL rst_wait_flags: got %b want 000001", got_f);
                end
                n_cmp++;
                if ({mem_addr, dm_rdata, if_rdata} !== '0) begin
                    n_bad++; $display("FAIL rst_wait_clear: got %h %h %h want zero", mem_addr, dm_rdata, if_rdata);
                end
            end else begin
                settle();
                got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
                exp_f = {c == 1 || c == 5, 1'b0, 1'b0, c == 8, 1'b0, c <= 7};
                n_cmp++;
                if (got_f !== exp_f) begin
                    n_bad++; $display("FAIL rst_wait_flags c%0d: got %b want %b", c, got_f, exp_f);
                end
                if (c == 5 || c == 8) begin
                    n_cmp++;
                    if (dm_rdata !== ((c == 5) ? 64'h0 : D3)) begin
                        n_bad++; $display("FAIL rst_wait_rdata c%0d: got %h", c, dm_rdata);
                    end
                end
            end
        end
    endtask

    // Timeline model: a grant at cycle g occupies the port until g+LAT+2; offsets fix every event.
    task automatic test_random();
        logic [5:0]  got_f, exp_f;
        logic [63:0] t_addr, t_wdata;
        logic [31:0] m_if;
        logic [63:0] m_dm;
        bit t_if, t_we, busy, drop, if_done, dm_done;
        bit e_en, e_ifv, e_dmv;
        int skip, g, k, cyc;
        busy = 0; drop = 0; skip = 0; g = 0; cyc = 0;
        if_done = 0; dm_done = 0; t_if = 0; t_we = 0;
        t_addr = '0; t_wdata = '0;
        m_if = 32'h0; m_dm = D3;
        while (cyc < 700) begin
            next_cycle();
            if (if_done) if_req = 1'b0;
            if (dm_done) dm_req = 1'b0;
            if_done = 0; dm_done = 0;
            if (cyc < 500 && !if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = {$urandom, $urandom} & ~64'h3;
            end
            if (cyc < 500 && !dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
            end
            flush = ($urandom_range(0, 7) == 0);
            mem_rdata = {$urandom, $urandom};
            if (cyc >= 500 && !busy && !if_req && !dm_req) break;

            if (!busy && (if_req || dm_req)) begin
                t_if = if_req && (!dm_req || skip >= SMAX);
                if (t_if) skip = 0;
                else if (if_req && skip < SMAX) skip++;
                busy = 1; drop = 0; g = cyc;
                t_addr  = t_if ? if_addr : dm_addr;
                t_we    = !t_if && dm_we;
                t_wdata = dm_wdata;
            end
            k = cyc - g;
            e_en  = busy && k == 1;
            e_ifv = busy && k == LAT + 2 && t_if && !drop && !flush;
            e_dmv = busy && k == LAT + 2 && !t_if;
            exp_f = {e_en, e_en && t_we, e_ifv, e_dmv, if_req && !e_ifv, dm_req && !e_dmv};

            settle();
            got_f = {mem_en, mem_we, if_valid, dm_valid, stall_if, stall_mem};
            n_cmp++;
            if (got_f !== exp_f) begin
                n_bad++; $display("FAIL rand_flags cyc%0d: got %b want %b", cyc, got_f, exp_f);
            end
            if (busy && k >= 1) begin
                n_cmp++;
                if (mem_addr !== t_addr) begin
                    n_bad++; $display("FAIL rand_addr cyc%0d: got %h want %h", cyc, mem_addr, t_addr);
                end
                if (t_we) begin
                    n_cmp++;
                    if (mem_wdata !== t_wdata) begin
                        n_bad++; $display("FAIL rand_wdata cyc%0d: got %h want %h", cyc, mem_wdata, t_wdata);
                    end
                end
            end
            n_cmp++;
            if (if_rdata !== m_if || dm_rdata !== m_dm) begin
                n_bad++; $display("FAIL rand_rdata cyc%0d: got %h/%h want %h/%h", cyc, if_rdata, dm_rdata, m_if, m_dm);
            end

            if (busy && k >= 1 && t_if && flush) drop = 1;
            if (busy && k == LAT + 1) begin
                if (t_if) m_if = mem_rdata[31:0];
                else if (!t_we) m_dm = mem_rdata;
            end
            if (busy && k == LAT + 2) begin
                busy = 0;
                if_done = e_ifv;
                dm_done = e_dmv;
            end
            cyc++;
        end
        n_cmp++;
        if (busy || if_req || dm_req) begin
            n_bad++; $display("FAIL rand_drain: busy=%0b if_req=%0b dm_req=%0b want all idle", busy, if_req, dm_req);
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_flush();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single shared memory port used by both instruction fetch (IF stage) and data load/store (MEM stage) of the pipelined RISC-V core. It accepts level-held requests from both stages and grants one at a time, with data taking priority and a starvation limit that protects fetch. It drives the memory port through a fixed-latency issue/wait/response sequence and produces per-stage stall signals for the pipeline registers. A flush input discards a pending fetch response after a taken branch.

## Interface
- ADDR_W, 64, byte address width
- DATA_W, 64, memory data width; fetch uses bits [31:0]
- MEM_LAT, 2, cycles from the mem_en cycle until mem_rdata is valid; legal range is 1 or more
- STARVE_MAX, 2, maximum consecutive data grants allowed while if_req is pending
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request, held until if_valid
- if_addr  input  ADDR_W  fetch address, stable while if_req
- if_rdata  output  32  fetched instruction, valid with if_valid
- if_valid  output  1  one-cycle fetch completion pulse
- dm_req  input  1  data request, held until dm_valid
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data, valid with dm_valid
- dm_valid  output  1  one-cycle data completion pulse
- flush  input  1  drop any in-flight or responding fetch
- stall_if  output  1  hold PC/IF_ID
- stall_mem  output  1  hold pipeline from MEM stage back
- mem_en  output  1  memory access strobe, exactly one cycle per access
- mem_we  output  1  write strobe, only with mem_en
- mem_addr  output  ADDR_W  access address
- mem_wdata  output  DATA_W  write data
- mem_rdata  input  DATA_W  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. An owner register (IF or DM) records the granted requester.
- IDLE: no request keeps the FSM in IDLE. Any request goes to ISSUE. Address, we and wdata of the winner are registered into mem_addr, mem_we and mem_wdata. For a fetch grant, mem_we = 0.
- Arbitration when both requests are present: DM wins unless skip_cnt == STARVE_MAX, in which case IF wins.
  - skip_cnt increments on each DM grant made while if_req = 1.
  - skip_cnt clears on any IF grant.
  - skip_cnt saturates at STARVE_MAX.
- ISSUE: mem_en = 1, plus mem_we for stores. Always goes to WAIT.
- WAIT: lasts exactly MEM_LAT cycles, tracked by a latency counter. In the last WAIT cycle, mem_rdata is captured (bits [31:0] to if_rdata, or the full word to dm_rdata). For stores, dm_rdata holds its old value. Then goes to RESP.
- RESP: the owner's valid pulses for one cycle, then the FSM returns to IDLE. A requester's req is ignored in its own RESP cycle.
- mem_addr, mem_we and mem_wdata are held from ISSUE through RESP. mem_we is gated by mem_en at the output.
- stall_if = if_req & ~(RESP & owner==IF). stall_mem = dm_req & ~(RESP & owner==DM). Both are combinational.
- Flush:
  - flush = 1 in any cycle of ISSUE, WAIT or RESP with owner==IF sets a drop flag, or masks the pulse directly if it arrives in RESP. The memory access still completes, and if_valid is suppressed for that transaction.
  - flush in IDLE, or with owner==DM, has no effect.
  - The drop flag clears on return to IDLE.

## Timing
- Request seen in IDLE at cycle T gives: ISSUE at T+1, WAIT from T+2 to T+1+MEM_LAT, valid at T+2+MEM_LAT, IDLE at T+3+MEM_LAT.
- Minimum spacing between grants is MEM_LAT+3 cycles. There is no back-to-back overlap.
- Reset (rst = 0, asynchronous):
  - State goes to IDLE; skip_cnt, latency counter and drop flag clear.
  - mem_en, mem_we, if_valid and dm_valid go to 0 immediately. mem_addr, mem_wdata, if_rdata and dm_rdata go to 0.
  - An in-flight transaction is abandoned and produces no valid after reset releases.
  - stall_if and stall_mem equal their req inputs during reset.
- Requests must be stable while stalled. Dropping a req before its valid is illegal, and the bench flags it.

## Test plan
- Fetch only, MEM_LAT=2: if_req=1 and if_addr=0x10 at cycle 0. Required: mem_en=1 with mem_addr=0x10 at cycle 1 only. The bench drives mem_rdata=0x00500093 at cycle 3. Required: if_valid=1 with if_rdata=0x00500093 at cycle 4, and stall_if=1 for cycles 0-3, 0 at cycle 4.
- Store: dm_req=1, dm_we=1, dm_addr=0x8, dm_wdata=0xDEADBEEF at cycle 0. Required: mem_en=mem_we=1 at cycle 1 only with that address and data, dm_valid at cycle 4, dm_rdata unchanged.
- Simultaneous if_req and dm_req (load, addr 0x20) at cycle 0. Required: DM is issued at cycle 1 and dm_valid pulses at cycle 4. IF is granted at cycle 5, issued at cycle 6, and if_valid pulses at cycle 9.
- Starvation, STARVE_MAX=2, both requests continuously re-asserted. Required grant order: DM, DM, IF, DM, DM, IF.
- Flush: fetch issued at cycle 1, flush=1 at cycle 2. Required: mem_en still pulses at cycle 1, no if_valid at cycle 4, the FSM is in IDLE at cycle 5, and stall_if stays 1 until a later fetch completes.
- Reset mid-WAIT: rst=0 at cycle 2 of a load. Required: mem_en and dm_valid are 0 immediately, and after release at cycle 4 no dm_valid appears until a new request completes its full sequence.
